dual_slope_adc_ctrl: RTL and testbench

Conversion sequencer for the dual-slope integrating ADC front end. It runs one conversion per trigger:
- auto-zero the integrator;
- integrate the unknown input for a fixed window;
- de-integrate against the reference while counting cycles until the comparator trips.

It returns the count as the conversion result and raises a sticky interrupt. It drives the analog switch controls and sits between the register/bus layer and the analog macro.

---
 rtl/dual_slope_adc_ctrl.sv | 177 +++++++++++++++++
 tb/tb_dual_slope_adc_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/dual_slope_adc_ctrl.sv
// Dual-slope integrating ADC conversion sequencer.
// Drives the auto-zero / integrate / de-integrate switches and measures the
// de-integrate time in clock cycles. That count is the conversion result.
module dual_slope_adc_ctrl #(
   parameter int unsigned CNT_W      = 12,
   parameter int unsigned INT_CYCLES = 4095,
   parameter int unsigned AZ_CYCLES  = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             trigger_i,
   input  logic             analog_ready_i,
   input  logic             comp_i,
   input  logic             interrupt_clear_i,
   output logic             autozero_o,
   output logic             integrate_o,
   output logic             deintegrate_o,
   output logic             busy_o,
   output logic [CNT_W-1:0] result_o,
   output logic             result_valid_o,
   output logic             overflow_o,
   output logic             abort_o,
   output logic             interrupt_o
);

   // The phase counter only ever holds values up to max(AZ, INT) - 1.
   localparam int unsigned PH_MAX = (AZ_CYCLES > INT_CYCLES) ? AZ_CYCLES : INT_CYCLES;
   localparam int unsigned PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
   localparam logic [PH_W-1:0] AZ_LAST  = PH_W'(AZ_CYCLES - 1);
   localparam logic [PH_W-1:0] INT_LAST = PH_W'(INT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_READY,
      S_AUTOZERO,
      S_INTEGRATE,
      S_DEINTEGRATE,
      S_DONE
   } state_t;

   state_t            state, state_nxt;
   logic [PH_W-1:0]   phase_cnt, phase_nxt;
   logic [CNT_W-1:0]  deint_cnt, deint_nxt;
   logic [CNT_W-1:0]  result_q, result_nxt;
   logic              overflow_q, overflow_nxt;
   logic              abort_q, abort_nxt;
   logic              irq_q, irq_nxt;
   logic              comp_m, comp_s;

   // Two-flop synchronizer for the asynchronous comparator output.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         comp_m <= 1'b0;
         comp_s <= 1'b0;
      end else begin
         comp_m <= comp_i;
         comp_s <= comp_m;
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state      <= S_IDLE;
         phase_cnt  <= '0;
         deint_cnt  <= '0;
         result_q   <= '0;
         overflow_q <= 1'b0;
         abort_q    <= 1'b0;
         irq_q      <= 1'b0;
      end else begin
         state      <= state_nxt;
         phase_cnt  <= phase_nxt;
         deint_cnt  <= deint_nxt;
         result_q   <= result_nxt;
         overflow_q <= overflow_nxt;
         abort_q    <= abort_nxt;
         irq_q      <= irq_nxt;
      end
   end

   // Next-state, counter and result logic.
   // Result and overflow are loaded on the edge into DONE so that they are
   // already valid while result_valid_o is high.
   always_comb begin
      state_nxt    = state;
      phase_nxt    = phase_cnt;
      deint_nxt    = deint_cnt;
      result_nxt   = result_q;
      overflow_nxt = overflow_q;
      abort_nxt    = 1'b0;

      case (state)
         S_IDLE: begin
            phase_nxt = '0;
            if (trigger_i) begin
               state_nxt = analog_ready_i ? S_AUTOZERO : S_WAIT_READY;
            end
         end
         S_WAIT_READY: begin
            phase_nxt = '0;
            if (analog_ready_i) begin
               state_nxt = S_AUTOZERO;
            end
         end
         S_AUTOZERO: begin
            if (!analog_ready_i) begin
               state_nxt = S_IDLE;
               abort_nxt = 1'b1;
            end else if (phase_cnt == AZ_LAST) begin
               state_nxt = S_INTEGRATE;
               phase_nxt = '0;
            end else begin
               phase_nxt = phase_cnt + PH_W'(1);
            end
         end
         S_INTEGRATE: begin
            if (!analog_ready_i) begin
               state_nxt = S_IDLE;
               abort_nxt = 1'b1;
            end else if (phase_cnt == INT_LAST) begin
               state_nxt = S_DEINTEGRATE;
               phase_nxt = '0;
               deint_nxt = '0;
            end else begin
               phase_nxt = phase_cnt + PH_W'(1);
            end
         end
         S_DEINTEGRATE: begin
            if (!analog_ready_i) begin
               state_nxt = S_IDLE;
               abort_nxt = 1'b1;
            end else if (!comp_s) begin
               state_nxt    = S_DONE;
               result_nxt   = deint_cnt;
               overflow_nxt = 1'b0;
            end else if (deint_cnt == '1) begin
               state_nxt    = S_DONE;
               result_nxt   = '1;
               overflow_nxt = 1'b1;
            end else begin
               deint_nxt = deint_cnt + CNT_W'(1);
            end
         end
         S_DONE: begin
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // Sticky interrupt: a set in DONE takes priority over a clear.
   always_comb begin
      irq_nxt = irq_q;
      if (state == S_DONE) begin
         irq_nxt = 1'b1;
      end else if (interrupt_clear_i) begin
         irq_nxt = 1'b0;
      end
   end

   // Outputs decoded from the state register or taken from registers.
   always_comb begin
      autozero_o     = (state == S_AUTOZERO);
      integrate_o    = (state == S_INTEGRATE);
      deintegrate_o  = (state == S_DEINTEGRATE);
      busy_o         = (state != S_IDLE);
      result_valid_o = (state == S_DONE);
      result_o       = result_q;
      overflow_o     = overflow_q;
      abort_o        = abort_q;
      interrupt_o    = irq_q;
   end

endmodule

// File: tb/tb_dual_slope_adc_ctrl.sv
// Self-checking bench for dual_slope_adc_ctrl (CNT_W=4, INT_CYCLES=8, AZ_CYCLES=2).
module tb_dual_slope_adc_ctrl;

   logic       clk = 1'b0;
   logic       rst, trig, ready, comp, clr;
   logic       az, intg, deint, busy, rv, ovf, abrt, irq;
   logic [3:0] result;
   logic [7:0] flags;

   int n_tests = 0;
   int n_fail  = 0;
   int onehot_err = 0;

   typedef struct {
      logic       trig, ready, comp, clr;
      logic [7:0] flags;
      logic [3:0] res;
   } vec_t;

   vec_t vecs[$];

   dual_slope_adc_ctrl #(
      .CNT_W(4),
      .INT_CYCLES(8),
      .AZ_CYCLES(2)
   ) dut (
      .clk_i(clk),
      .rst_i(rst),
      .trigger_i(trig),
      .analog_ready_i(ready),
      .comp_i(comp),
      .interrupt_clear_i(clr),
      .autozero_o(az),
      .integrate_o(intg),
      .deintegrate_o(deint),
      .busy_o(busy),
      .result_o(result),
      .result_valid_o(rv),
      .overflow_o(ovf),
      .abort_o(abrt),
      .interrupt_o(irq)
   );

   always #5 clk = ~clk;

   // flag order: autozero, integrate, deintegrate, busy, valid, overflow, abort, interrupt
   assign flags = {az, intg, deint, busy, rv, ovf, abrt, irq};

   always @(negedge clk) begin
      if ((32'(az) + 32'(intg) + 32'(deint)) > 1) onehot_err++;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic void add(input logic t, input logic r, input logic c, input logic k,
                               input logic [7:0] f, input logic [3:0] res);
      vec_t v;
      v.trig = t; v.ready = r; v.comp = c; v.clr = k; v.flags = f; v.res = res;
      vecs.push_back(v);
   endfunction

   // Runs until result_valid_o, counting edges and switch-phase cycles.
   task automatic run_to_rv(input bit start, input bit hold, input int pulse_at,
                            output int edges, output int n_az, output int n_int,
                            output int n_de, output bit ok);
      edges = 0; n_az = 0; n_int = 0; n_de = 0; ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         trig = (start && i == 0) || hold || (i == pulse_at);
         step();
         edges++;
         if (az)    n_az++;
         if (intg)  n_int++;
         if (deint) n_de++;
         if (rv) begin
            ok = 1'b1;
            break;
         end
      end
      trig = hold;
   endtask

   int edges, n_az, n_int, n_de;
   bit ok;

   initial begin
      rst = 1'b1; trig = 1'b0; ready = 1'b1; comp = 1'b1; clr = 1'b0;
      step();
      step();
      check("reset_flags", 32'(flags), 32'h00);
      check("reset_result", 32'(result), 32'h0);
      rst = 1'b0;
      step(); step(); step();

      // Nominal conversion: comp_s falls in the 6th de-integrate cycle -> result 5.
      add(1, 1, 1, 0, 8'b1001_0000, 4'd0);
      add(0, 1, 1, 0, 8'b1001_0000, 4'd0);
      for (int i = 0; i < 8; i++) add(0, 1, 1, 0, 8'b0101_0000, 4'd0);
      for (int i = 0; i < 4; i++) add(0, 1, 1, 0, 8'b0011_0000, 4'd0);
      add(0, 1, 0, 0, 8'b0011_0000, 4'd0);
      add(0, 1, 0, 0, 8'b0011_0000, 4'd0);
      add(0, 1, 0, 0, 8'b0001_1000, 4'd5);
      add(0, 1, 0, 0, 8'b0000_0001, 4'd5);
      add(0, 1, 0, 0, 8'b0000_0001, 4'd5);
      add(0, 1, 0, 1, 8'b0000_0000, 4'd5);
      add(0, 1, 0, 0, 8'b0000_0000, 4'd5);

      foreach (vecs[i]) begin
         trig = vecs[i].trig; ready = vecs[i].ready; comp = vecs[i].comp; clr = vecs[i].clr;
         step();
         check($sformatf("vec%0d_flags", i), 32'(flags), 32'(vecs[i].flags));
         check($sformatf("vec%0d_result", i), 32'(result), 32'(vecs[i].res));
      end
      trig = 1'b0; clr = 1'b0;

      // Overflow: comp held high.
      comp = 1'b1;
      step(); step();
      run_to_rv(1'b1, 1'b0, -1, edges, n_az, n_int, n_de, ok);
      check("ovf_done", 32'(ok), 32'd1);
      check("ovf_latency", 32'(edges), 32'd27);
      check("ovf_az_cycles", 32'(n_az), 32'd2);
      check("ovf_int_cycles", 32'(n_int), 32'd8);
      check("ovf_de_cycles", 32'(n_de), 32'd16);
      check("ovf_result", 32'(result), 32'hF);
      check("ovf_flag", 32'(ovf), 32'd1);
      step();
      check("ovf_irq", 32'(irq), 32'd1);

      // Wait for ready, then abort in the 4th integrate cycle.
      trig = 1'b1; ready = 1'b0;
      step();
      trig = 1'b0;
      check("wait_enter", 32'(flags), 32'b0001_0101);
      step(); step();
      check("wait_hold", 32'(flags), 32'b0001_0101);
      ready = 1'b1;
      step();
      check("wait_to_az", 32'(flags), 32'b1001_0101);
      step(); step(); step(); step(); step();
      check("abort_int4", 32'(flags), 32'b0101_0101);
      ready = 1'b0;
      step();
      check("abort_pulse", 32'(flags), 32'b0000_0111);
      check("abort_result", 32'(result), 32'hF);
      ready = 1'b1;
      step();
      check("abort_after", 32'(flags), 32'b0000_0101);

      // Interrupt race: clear during DONE loses, clear one cycle later wins.
      clr = 1'b1;
      step();
      check("irq_clear", 32'(irq), 32'd0);
      clr = 1'b0; comp = 1'b0;
      step(); step();
      run_to_rv(1'b1, 1'b0, -1, edges, n_az, n_int, n_de, ok);
      check("race_done", 32'(ok), 32'd1);
      check("race_latency", 32'(edges), 32'd12);
      check("race_result", 32'(result), 32'h0);
      check("race_ovf", 32'(ovf), 32'd0);
      clr = 1'b1;
      step();
      check("race_set_wins", 32'(irq), 32'd1);
      step();
      check("race_clear_later", 32'(irq), 32'd0);
      clr = 1'b0;

      // Trigger pulse during INTEGRATE is ignored.
      run_to_rv(1'b1, 1'b0, 5, edges, n_az, n_int, n_de, ok);
      check("ign_done", 32'(ok), 32'd1);
      check("ign_latency", 32'(edges), 32'd12);
      step();
      step();
      check("ign_no_restart", 32'(flags), 32'b0000_0001);

      // Back-to-back: trigger held through DONE.
      run_to_rv(1'b1, 1'b1, -1, edges, n_az, n_int, n_de, ok);
      check("b2b_done", 32'(ok), 32'd1);
      step();
      check("b2b_idle", 32'({az, busy}), 32'b00);
      step();
      check("b2b_az", 32'({az, busy}), 32'b11);
      run_to_rv(1'b0, 1'b0, -1, edges, n_az, n_int, n_de, ok);
      check("b2b_second", 32'(edges), 32'd11);
      step();

      // Reset in the middle of DEINTEGRATE.
      comp = 1'b1;
      step(); step();
      run_to_rv(1'b1, 1'b0, -1, edges, n_az, n_int, n_de, ok);
      check("rst_pre_result", 32'(result), 32'hF);
      step();
      trig = 1'b1;
      step();
      trig = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (deint) begin
            ok = 1'b1;
            break;
         end
      end
      check("rst_reach_deint", 32'(ok), 32'd1);
      step(); step(); step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("rst_flags", 32'(flags), 32'h00);
      check("rst_result", 32'(result), 32'h0);
      check("rst_comp_s", 32'(dut.comp_s), 32'd0);
      step();
      check("rst_idle", 32'(busy), 32'd0);

      check("switch_onehot", 32'(onehot_err), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
